hazard_ctl: RTL

- Parametrised hazard unit for the rv32 pipeline. It generalises the fixed fetch/decode/execute/access/writeback control chain to a configurable number of in-flight stages.
- Keeps a scoreboard shift register of destination registers for instructions past decode.
- Generates forwarding selects, load-use stalls and branch-redirect flushes, with optional stall-only mode.
- Sits beside the decode and execute control blocks; its outputs drive the ALU operand muxes and the pipeline-register enables and flushes.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_match.sv | 59 +++++
 rtl/hazard_ctl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and helpers for the pipeline hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Slot rd field is sized for the largest supported register file.
    localparam int c_RD_W_MAX = 8;
    localparam int c_FWD_RF   = 0;

    typedef struct packed {
        logic                  v;
        logic [c_RD_W_MAX-1:0] rd;
        logic                  we;
        logic                  ld;
    } slot_t;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// ============================================================================
// Module      : hazard_match
// Description : Youngest-producer search for one source operand.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_match
    import hazard_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int FWD_EN   = 1,
    parameter int REG_W    = 5,
    parameter int SEL_W    = sel_width(DEPTH)
) (
    input  slot_t [DEPTH-1:0] i_slots,
    input  logic  [REG_W-1:0] i_src,
    input  logic              i_used,
    output logic              o_hazard,
    output logic  [SEL_W-1:0] o_fwd_sel
);

    logic [DEPTH-1:0]      w_match;
    logic [DEPTH-1:0]      w_not_ready;
    logic [c_RD_W_MAX-1:0] w_src_ext;
    logic                  w_hazard;
    logic [SEL_W-1:0]      w_sel;

    assign w_src_ext = c_RD_W_MAX'(i_src);

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        localparam logic c_YOUNG = (i < LOAD_LAT);
        assign w_match[i]     = i_used && (i_src != '0) && i_slots[i].v &&
                                i_slots[i].we && (i_slots[i].rd == w_src_ext);
        assign w_not_ready[i] = i_slots[i].ld & c_YOUNG;
    end

    // Walk oldest to youngest so the youngest matching slot has the last word.
    always_comb begin
        w_hazard = 1'b0;
        w_sel    = SEL_W'(c_FWD_RF);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                if (FWD_EN == 0 || w_not_ready[i]) begin
                    w_hazard = 1'b1;
                    w_sel    = SEL_W'(c_FWD_RF);
                end else begin
                    w_hazard = 1'b0;
                    w_sel    = SEL_W'(i + 1);
                end
            end
        end
    end

    assign o_hazard  = w_hazard;
    assign o_fwd_sel = w_sel;

endmodule
`default_nettype wire

// File: rtl/hazard_ctl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctl
// Description : Scoreboard-based forwarding, load-use stall and redirect flush.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctl
    import hazard_pkg::*;
#(
    parameter  int XLEN     = 32,
    parameter  int NREG     = 32,
    parameter  int DEPTH    = 3,
    parameter  int LOAD_LAT = 1,
    parameter  int FWD_EN   = 1,
    parameter  int CNT_W    = 16,
    localparam int REG_W    = $clog2(NREG),
    localparam int SEL_W    = sel_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             de_valid,
    input  logic [REG_W-1:0] de_rs1,
    input  logic [REG_W-1:0] de_rs2,
    input  logic             de_rs1_used,
    input  logic             de_rs2_used,
    input  logic [REG_W-1:0] de_rd,
    input  logic             de_rd_we,
    input  logic             de_is_load,
    input  logic             exe_redirect,
    output logic             stall,
    output logic             flush_fetch,
    output logic             flush_de,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    if (CNT_W > XLEN || REG_W > c_RD_W_MAX) begin : g_param_check
        $error("hazard_ctl: CNT_W must not exceed XLEN and REG_W must fit the slot rd field");
    end

    slot_t [DEPTH-1:0] r_slot_q;
    slot_t [DEPTH-1:0] w_slot_d;
    logic  [CNT_W-1:0] r_stall_cnt_q;
    logic  [CNT_W-1:0] w_stall_cnt_d;
    logic  [CNT_W-1:0] r_flush_cnt_q;
    logic  [CNT_W-1:0] w_flush_cnt_d;
    logic              w_haz_a;
    logic              w_haz_b;
    logic              w_stall;

    hazard_match #(
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT),
        .FWD_EN   (FWD_EN),
        .REG_W    (REG_W),
        .SEL_W    (SEL_W)
    ) u_match_a (
        .i_slots   (r_slot_q),
        .i_src     (de_rs1),
        .i_used    (de_rs1_used),
        .o_hazard  (w_haz_a),
        .o_fwd_sel (fwd_a_sel)
    );

    hazard_match #(
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT),
        .FWD_EN   (FWD_EN),
        .REG_W    (REG_W),
        .SEL_W    (SEL_W)
    ) u_match_b (
        .i_slots   (r_slot_q),
        .i_src     (de_rs2),
        .i_used    (de_rs2_used),
        .o_hazard  (w_haz_b),
        .o_fwd_sel (fwd_b_sel)
    );

    // A redirect drops the decode instruction rather than holding it.
    assign w_stall     = de_valid && (w_haz_a || w_haz_b) && !exe_redirect;
    assign stall       = w_stall;
    assign flush_fetch = exe_redirect;
    assign flush_de    = exe_redirect;

    always_comb begin
        w_slot_d = '0;
        for (int i = DEPTH - 1; i >= 1; i--) begin
            w_slot_d[i] = r_slot_q[i-1];
        end
        if (de_valid && !w_stall && !exe_redirect) begin
            w_slot_d[0].v  = 1'b1;
            w_slot_d[0].rd = c_RD_W_MAX'(de_rd);
            w_slot_d[0].we = de_rd_we;
            w_slot_d[0].ld = de_is_load;
        end
    end

    always_comb begin
        w_stall_cnt_d = r_stall_cnt_q;
        w_flush_cnt_d = r_flush_cnt_q;
        if (w_stall && r_stall_cnt_q != '1) begin
            w_stall_cnt_d = r_stall_cnt_q + 1'b1;
        end
        if (exe_redirect && r_flush_cnt_q != '1) begin
            w_flush_cnt_d = r_flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_q      <= '0;
            r_stall_cnt_q <= '0;
            r_flush_cnt_q <= '0;
        end else begin
            r_slot_q      <= w_slot_d;
            r_stall_cnt_q <= w_stall_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
        end
    end

    assign stall_cnt = r_stall_cnt_q;
    assign flush_cnt = r_flush_cnt_q;

endmodule
`default_nettype wire
